// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS on the bus,
// one-cycle response strobe out. Every ACCESS phase is bounded by a timeout.
module apb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_ready_d, psel_d, penable_d, pwrite_d, rsp_valid_d, rsp_error_d;
  logic [31:0]      paddr_d, pwdata_d, rsp_rdata_d;

  // cmd_ready comes up one edge after reset release, so a command is only
  // ever accepted when cmd_ready is visibly high.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error;
    rsp_rdata_d = rsp_rdata;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        if (cmd_ready && cmd_valid) begin
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          psel_d      = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        // pready is checked before the timeout so a late-but-valid ready still completes.
        if (pready) begin
          rsp_rdata_d = pwrite ? 32'h0 : prdata;
          rsp_error_d = 1'b0;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_rdata_d = 32'h0;
          rsp_error_d = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        rsp_error_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cmd_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 32'h0;
      pwdata    <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_ready <= cmd_ready_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_error <= rsp_error_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a behavioural register slave whose
// wait states (or total silence) are set per step.
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        rst  = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0, cmd_wdata = 32'h0;
  logic        cmd_ready, rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready;
  logic [31:0] paddr, pwdata, prdata;

  int tests = 0;
  int fails = 0;

  apb_master_bridge #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .pclk(pclk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  // Register slave: 16 words at paddr[5:2], ready after wait_states ACCESS cycles.
  int          wait_states = 0;
  bit          never_ready = 1'b0;
  int          wcnt = 0;
  int          wr_count = 0, rd_count = 0, xfer_n = 0;
  logic [31:0] mem [0:15];
  logic [31:0] log_addr [0:31];
  logic [31:0] log_data [0:31];
  logic        log_write [0:31];

  assign pready = psel && penable && !never_ready && (wcnt == wait_states);
  assign prdata = mem[paddr[5:2]];

  always @(posedge pclk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (psel && penable && pready) begin
      if (pwrite) begin
        mem[paddr[5:2]] <= pwdata;
        wr_count <= wr_count + 1;
      end else begin
        rd_count <= rd_count + 1;
      end
      if (xfer_n < 32) begin
        log_addr[xfer_n]  <= paddr;
        log_write[xfer_n] <= pwrite;
        log_data[xfer_n]  <= pwrite ? pwdata : prdata;
      end
      xfer_n <= xfer_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the bridge idle; returns at the negedge after RESP.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rdata, output logic err, output int pen);
    int guard;
    pen   = 0;
    guard = 0;
    check_b("pre_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(negedge pclk);
    cmd_valid = 1'b0;
    check_b("setup_psel", psel, 1'b1);
    check_b("setup_penable", penable, 1'b0);
    check_b("setup_cmd_ready", cmd_ready, 1'b0);
    check("setup_paddr", paddr, a);
    check_b("setup_pwrite", pwrite, w);
    if (w) check("setup_pwdata", pwdata, d);
    @(negedge pclk);
    while (!rsp_valid && guard < 64) begin
      if (penable) pen++;
      @(negedge pclk);
      guard++;
    end
    check_b("rsp_seen", rsp_valid, 1'b1);
    rdata = rsp_rdata;
    err   = rsp_error;
    check_b("resp_psel_idle", psel, 1'b0);
    check_b("resp_penable_idle", penable, 1'b0);
    check_b("resp_cmd_ready", cmd_ready, 1'b0);
    @(negedge pclk);
    check_b("post_rsp_valid", rsp_valid, 1'b0);
    check_b("post_rsp_error", rsp_error, 1'b0);
    check_b("post_cmd_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          pen;
    int          wr0, rd0, base, resp_n, idx, seen;
    logic        c_w [0:3];
    logic [31:0] c_a [0:3];
    logic [31:0] c_d [0:3];
    logic [31:0] got_rd [0:3];
    logic        got_er [0:3];

    // Reset state: every output low while rst is held.
    #2;
    check_b("rst_cmd_ready", cmd_ready, 1'b0);
    check_b("rst_psel", psel, 1'b0);
    check_b("rst_penable", penable, 1'b0);
    check_b("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    check_b("release_cmd_ready", cmd_ready, 1'b1);
    check_b("release_psel", psel, 1'b0);

    // Zero-wait write: one ACCESS cycle, response on the third edge counting the accept edge.
    wait_states = 0;
    run_txn(1'b1, 32'h0, 32'hDEADBEEF, rd, er, pen);
    check("zw_access_cycles", 32'(pen), 32'd1);
    check_b("zw_error", er, 1'b0);
    check("zw_rdata", rd, 32'h0);

    // GPIO-style write then read of the same register.
    wr0 = wr_count; rd0 = rd_count;
    run_txn(1'b1, 32'h0, 32'h0000_00A5, rd, er, pen);
    check_b("gpio_wr_error", er, 1'b0);
    run_txn(1'b0, 32'h0, 32'h0, rd, er, pen);
    check("gpio_rd_data", rd, 32'h0000_00A5);
    check_b("gpio_rd_error", er, 1'b0);
    check("gpio_write_count", 32'(wr_count - wr0), 32'd1);
    check("gpio_read_count", 32'(rd_count - rd0), 32'd1);

    // Silent slave: penable for exactly 16 cycles, then an error response with zero data.
    never_ready = 1'b1;
    run_txn(1'b0, 32'h10, 32'h0, rd, er, pen);
    check("to_access_cycles", 32'(pen), 32'd16);
    check_b("to_error", er, 1'b1);
    check("to_rdata", rd, 32'h0);
    never_ready = 1'b0;

    // pready in the 16th ACCESS cycle wins over the timeout.
    wait_states = 0;
    run_txn(1'b1, 32'hC, 32'hCAFEF00D, rd, er, pen);
    wait_states = 15;
    run_txn(1'b0, 32'hC, 32'h0, rd, er, pen);
    check("late_access_cycles", 32'(pen), 32'd16);
    check_b("late_error", er, 1'b0);
    check("late_rdata", rd, 32'hCAFEF00D);

    // Four back-to-back commands with cmd_valid held high, two wait states each.
    wait_states = 2;
    c_w[0] = 1'b1; c_a[0] = 32'h4; c_d[0] = 32'h1111_1111;
    c_w[1] = 1'b0; c_a[1] = 32'h4; c_d[1] = 32'h0;
    c_w[2] = 1'b1; c_a[2] = 32'h8; c_d[2] = 32'h2222_2222;
    c_w[3] = 1'b0; c_a[3] = 32'h8; c_d[3] = 32'h0;
    base = xfer_n; resp_n = 0; idx = 0;
    cmd_valid = 1'b1; cmd_write = c_w[0]; cmd_addr = c_a[0]; cmd_wdata = c_d[0];
    for (int c = 0; c < 200 && resp_n < 4; c++) begin
      @(negedge pclk);
      if (psel && !penable) begin
        idx++;
        if (idx < 4) begin
          cmd_write = c_w[idx]; cmd_addr = c_a[idx]; cmd_wdata = c_d[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (rsp_valid) begin
        got_rd[resp_n] = rsp_rdata;
        got_er[resp_n] = rsp_error;
        resp_n++;
      end
    end
    cmd_valid = 1'b0;
    @(negedge pclk);
    check("b2b_responses", 32'(resp_n), 32'd4);
    check("b2b_transfers", 32'(xfer_n - base), 32'd4);
    if (resp_n == 4 && xfer_n - base == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("b2b_addr", log_addr[base + i], c_a[i]);
        check_b("b2b_write", log_write[base + i], c_w[i]);
        check_b("b2b_error", got_er[i], 1'b0);
      end
      check("b2b_wdata0", log_data[base], 32'h1111_1111);
      check("b2b_rdata1", got_rd[1], 32'h1111_1111);
      check("b2b_wdata2", log_data[base + 2], 32'h2222_2222);
      check("b2b_rdata3", got_rd[3], 32'h2222_2222);
    end

    // Reset asserted mid-ACCESS: bus drops at once and no response follows.
    never_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    check_b("pre_rst_penable", penable, 1'b1);
    rst = 1'b0;
    #1;
    check_b("midrst_psel", psel, 1'b0);
    check_b("midrst_penable", penable, 1'b0);
    check_b("midrst_rsp_valid", rsp_valid, 1'b0);
    @(negedge pclk);
    rst = 1'b1;
    never_ready = 1'b0;
    wait_states = 0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge pclk);
      if (rsp_valid) seen++;
    end
    check("midrst_no_response", 32'(seen), 32'd0);
    check_b("midrst_cmd_ready", cmd_ready, 1'b1);
    run_txn(1'b0, 32'hC, 32'h0, rd, er, pen);
    check("after_rst_rdata", rd, 32'hCAFEF00D);
    check_b("after_rst_error", er, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
